// File: rtl/input_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_fsm
// Brief    : Two-flop synchronizer followed by a four-state debounce FSM.
//            Optional glitch counter is enabled by macro DEBOUNCE_GLITCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce_fsm #(
   parameter int DEBOUNCE_LEN = 4,
   parameter int CNT_W        = 4
) (
   input  logic       c,
   input  logic       rst_n,
   input  logic       raw_in,
   output logic       in_clean,
   output logic       rise_p,
   output logic       fall_p
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   typedef enum logic [3:0] {
      ST_LOW  = 4'b0001,
      ST_RISE = 4'b0010,
      ST_HIGH = 4'b0100,
      ST_FALL = 4'b1000
   } state_t;

   localparam logic [CNT_W-1:0] c_LEN  = CNT_W'(DEBOUNCE_LEN);
   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_ZERO = '0;
   // A single-sample debounce skips the pending states entirely.
   localparam state_t c_RISE_DST = (DEBOUNCE_LEN == 1) ? ST_HIGH : ST_RISE;
   localparam state_t c_FALL_DST = (DEBOUNCE_LEN == 1) ? ST_LOW  : ST_FALL;

   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state_a;
   state_t           r_state_b;
   state_t           r_state_c;
   logic [3:0]       w_voted;
   state_t           w_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_clean_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             r_in_clean;
   logic             r_rise_p;
   logic             r_fall_p;

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw_in;
         r_sync2 <= r_sync1;
      end
   end

   // Three state copies, bitwise majority; a corrupted copy is outvoted.
   assign w_voted   = (r_state_a & r_state_b) | (r_state_a & r_state_c) | (r_state_b & r_state_c);
   assign w_state   = state_t'(w_voted);
   assign w_cnt_inc = r_cnt + c_ONE;

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_state_a  <= ST_LOW;
         r_state_b  <= ST_LOW;
         r_state_c  <= ST_LOW;
         r_cnt      <= c_ZERO;
         r_in_clean <= 1'b0;
         r_rise_p   <= 1'b0;
         r_fall_p   <= 1'b0;
      end else begin
         r_state_a  <= w_state_nxt;
         r_state_b  <= w_state_nxt;
         r_state_c  <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_in_clean <= w_clean_nxt;
         r_rise_p   <= w_rise_nxt;
         r_fall_p   <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      w_cnt_nxt   = r_cnt;
      w_clean_nxt = 1'b0;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (w_state)
         ST_LOW: begin
            if (r_sync2) begin
               w_cnt_nxt   = c_ONE;
               w_state_nxt = c_RISE_DST;
            end
         end
         ST_RISE: begin
            if (r_sync2) begin
               w_cnt_nxt   = w_cnt_inc;
               w_state_nxt = (w_cnt_inc == c_LEN) ? ST_HIGH : ST_RISE;
            end else begin
               w_cnt_nxt   = c_ZERO;
               w_state_nxt = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (!r_sync2) begin
               w_cnt_nxt   = c_ONE;
               w_state_nxt = c_FALL_DST;
            end
         end
         ST_FALL: begin
            if (!r_sync2) begin
               w_cnt_nxt   = w_cnt_inc;
               w_state_nxt = (w_cnt_inc == c_LEN) ? ST_LOW : ST_FALL;
            end else begin
               w_cnt_nxt   = c_ZERO;
               w_state_nxt = ST_HIGH;
            end
         end
         default: begin
            w_cnt_nxt   = c_ZERO;
            w_state_nxt = ST_LOW;
         end
      endcase

      // Output decode is derived only from legal states so recovery is silent.
      case (w_state)
         ST_LOW, ST_RISE: begin
            w_clean_nxt = (w_state_nxt == ST_HIGH);
            w_rise_nxt  = (w_state_nxt == ST_HIGH);
         end
         ST_HIGH, ST_FALL: begin
            w_clean_nxt = (w_state_nxt != ST_LOW);
            w_fall_nxt  = (w_state_nxt == ST_LOW);
         end
         default: begin
            w_clean_nxt = 1'b0;
         end
      endcase
   end

   assign in_clean = r_in_clean;
   assign rise_p   = r_rise_p;
   assign fall_p   = r_fall_p;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic       w_glitch;
   logic [7:0] r_glitch_cnt;

   assign w_glitch = ((w_state == ST_RISE) && !r_sync2) || ((w_state == ST_FALL) && r_sync2);

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_glitch_cnt <= 8'd0;
      end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
         r_glitch_cnt <= r_glitch_cnt + 8'd1;
      end
   end

   assign glitch_cnt = r_glitch_cnt;
`else
   // Glitch counter not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debounce_fsm
// Brief    : Randomized and directed bench for input_debounce_fsm against a
//            run-length reference model. Honours DEBOUNCE_GLITCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debounce_fsm;
   localparam int L = 4;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   localparam logic [10:0] MASK = 11'h7FF;
`else
   localparam logic [10:0] MASK = 11'h700;
`endif

   logic       c = 1'b0;
   logic       rst_n = 1'b0;
   logic       raw_in = 1'b0;
   logic       in_clean;
   logic       rise_p;
   logic       fall_p;
   logic [7:0] glitch_cnt;

   int chk = 0;
   int errs = 0;

   // Reference model: synchronizer pipe plus length of the current run of
   // samples that disagree with the debounced level.
   logic       m_s1, m_s2, m_clean, m_rise, m_fall;
   int         m_run;
   logic [7:0] m_glitch;

   always #5 c = ~c;

   input_debounce_fsm #(.DEBOUNCE_LEN(L), .CNT_W(4)) dut (
      .c        (c),
      .rst_n    (rst_n),
      .raw_in   (raw_in),
      .in_clean (in_clean),
      .rise_p   (rise_p),
      .fall_p   (fall_p)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt)
`endif
   );
`ifndef DEBOUNCE_GLITCH_CNT_EN
   assign glitch_cnt = 8'd0;
`endif

   task automatic m_reset();
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0;
      m_run = 0; m_glitch = 8'd0;
   endtask

   // Drive one sample, advance the model on the rising edge, return at negedge.
   task automatic tick(input logic v);
      raw_in = v;
      @(posedge c);
      if (!rst_n) begin
         m_reset();
      end else begin
         m_rise = 0;
         m_fall = 0;
         if (m_s2 != m_clean) begin
            m_run++;
            if (m_run == L) begin
               m_clean = ~m_clean;
               m_run   = 0;
               if (m_clean) m_rise = 1; else m_fall = 1;
            end
         end else begin
            if (m_run > 0 && m_glitch != 8'd255) m_glitch++;
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = v;
      end
      @(negedge c);
   endtask

   task automatic test_reset();
      raw_in = 1'b1;
      rst_n  = 1'b0;
      m_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         chk++;
         if ({in_clean, rise_p, fall_p, glitch_cnt} !== 11'd0) begin
            errs++;
            $display("FAIL reset_hold: got %b/%b/%b/%0d want 0/0/0/0", in_clean, rise_p, fall_p, glitch_cnt);
         end
      end
      rst_n = 1'b1;
      begin
         int t;
         t = 0;
         while (!in_clean && t < 20) begin
            tick(1'b1);
            t++;
            chk++;
            if (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK)) begin
               errs++;
               $display("FAIL reset_release: got %b/%b/%b/%0d want %b/%b/%b/%0d",
                        in_clean, rise_p, fall_p, glitch_cnt, m_clean, m_rise, m_fall, m_glitch);
            end
         end
         chk++;
         if (t != L + 2 || rise_p !== 1'b1) begin
            errs++;
            $display("FAIL reset_latency: got %0d ticks rise=%b want %0d ticks rise=1", t, rise_p, L + 2);
         end
      end
      tick(1'b1);
      chk++;
      if (rise_p !== 1'b0 || in_clean !== 1'b1) begin
         errs++;
         $display("FAIL reset_pulse_width: got rise=%b clean=%b want 0/1", rise_p, in_clean);
      end
   endtask

   task automatic test_rise_latency();
      int t;
      for (int i = 0; i < 8; i++) tick(1'b0);
      chk++;
      if (in_clean !== 1'b0) begin
         errs++;
         $display("FAIL rise_pre: got clean=%b want 0", in_clean);
      end
      t = 0;
      while (!in_clean && t < 20) begin
         tick(1'b1);
         t++;
         chk++;
         if (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK)) begin
            errs++;
            $display("FAIL rise_trace: got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     in_clean, rise_p, fall_p, glitch_cnt, m_clean, m_rise, m_fall, m_glitch);
         end
      end
      chk++;
      if (t != L + 2 || rise_p !== 1'b1 || fall_p !== 1'b0) begin
         errs++;
         $display("FAIL rise_latency: got %0d ticks rise=%b fall=%b want %0d/1/0", t, rise_p, fall_p, L + 2);
      end
      tick(1'b1);
      chk++;
      if (rise_p !== 1'b0) begin
         errs++;
         $display("FAIL rise_one_cycle: got rise=%b want 0", rise_p);
      end
   endtask

   task automatic test_rise_glitch();
      logic [7:0] g0;
      for (int i = 0; i < 8; i++) tick(1'b0);
      g0 = glitch_cnt;
      for (int i = 0; i < 10; i++) begin
         tick(i < 2 ? 1'b1 : 1'b0);
         chk++;
         if (in_clean !== 1'b0 || rise_p !== 1'b0 || fall_p !== 1'b0 ||
             (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK))) begin
            errs++;
            $display("FAIL rise_glitch: got %b/%b/%b/%0d want 0/0/0/%0d", in_clean, rise_p, fall_p, glitch_cnt, m_glitch);
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk++;
      if (glitch_cnt !== g0 + 8'd1) begin
         errs++;
         $display("FAIL rise_glitch_count: got %0d want %0d", glitch_cnt, g0 + 8'd1);
      end
`endif
   endtask

   task automatic test_fall_glitch();
      logic [7:0] g0;
      int t;
      for (int i = 0; i < 10; i++) tick(1'b1);
      g0 = glitch_cnt;
      for (int i = 0; i < 10; i++) begin
         tick(i < 3 ? 1'b0 : 1'b1);
         chk++;
         if (in_clean !== 1'b1 || rise_p !== 1'b0 || fall_p !== 1'b0 ||
             (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK))) begin
            errs++;
            $display("FAIL fall_glitch: got %b/%b/%b/%0d want 1/0/0/%0d", in_clean, rise_p, fall_p, glitch_cnt, m_glitch);
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk++;
      if (glitch_cnt !== g0 + 8'd1) begin
         errs++;
         $display("FAIL fall_glitch_count: got %0d want %0d", glitch_cnt, g0 + 8'd1);
      end
`endif
      t = 0;
      while (!fall_p && t < 20) begin
         tick(1'b0);
         t++;
      end
      chk++;
      if (t != L + 2 || in_clean !== 1'b0 || rise_p !== 1'b0) begin
         errs++;
         $display("FAIL fall_latency: got %0d ticks clean=%b rise=%b want %0d/0/0", t, in_clean, rise_p, L + 2);
      end
   endtask

   task automatic test_random();
      logic v;
      v = raw_in;
      for (int r = 0; r < 400; r++) begin
         int len;
         v   = ~v;
         len = int'($urandom_range(1, 2 * L + 1));
         for (int i = 0; i < len; i++) begin
            tick(v);
            chk++;
            if (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK) ||
                (rise_p && fall_p)) begin
               errs++;
               $display("FAIL random: got %b/%b/%b/%0d want %b/%b/%b/%0d",
                        in_clean, rise_p, fall_p, glitch_cnt, m_clean, m_rise, m_fall, m_glitch);
            end
         end
      end
   endtask

   task automatic test_saturate();
      logic c0;
      for (int i = 0; i < 10; i++) tick(1'b0);
      c0 = in_clean;
      for (int g = 0; g < 300; g++) begin
         for (int i = 0; i < 4; i++) begin
            tick(i < 2 ? 1'b1 : 1'b0);
            chk++;
            if (in_clean !== c0 || rise_p !== 1'b0 || fall_p !== 1'b0 ||
                (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK))) begin
               errs++;
               $display("FAIL saturate_trace: got %b/%b/%b/%0d want %b/0/0/%0d", in_clean, rise_p, fall_p, glitch_cnt, c0, m_glitch);
            end
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk++;
      if (glitch_cnt !== 8'd255) begin
         errs++;
         $display("FAIL saturate_count: got %0d want 255", glitch_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int t;
      for (int i = 0; i < 10; i++) tick(1'b0);
      for (int i = 0; i < 5; i++) tick(1'b1);
      chk++;
      if (in_clean !== 1'b0 || rise_p !== 1'b0) begin
         errs++;
         $display("FAIL mid_pending: got clean=%b rise=%b want 0/0", in_clean, rise_p);
      end
      rst_n = 1'b0;
      m_reset();
      #1;
      chk++;
      if ({in_clean, rise_p, fall_p, glitch_cnt} !== 11'd0) begin
         errs++;
         $display("FAIL mid_reset: got %b/%b/%b/%0d want 0/0/0/0", in_clean, rise_p, fall_p, glitch_cnt);
      end
      tick(1'b1);
      tick(1'b1);
      rst_n = 1'b1;
      t = 0;
      while (!in_clean && t < 20) begin
         tick(1'b1);
         t++;
         chk++;
         if (({in_clean, rise_p, fall_p, glitch_cnt} & MASK) !== ({m_clean, m_rise, m_fall, m_glitch} & MASK)) begin
            errs++;
            $display("FAIL mid_release: got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     in_clean, rise_p, fall_p, glitch_cnt, m_clean, m_rise, m_fall, m_glitch);
         end
      end
      chk++;
      if (t != L + 2 || rise_p !== 1'b1) begin
         errs++;
         $display("FAIL mid_latency: got %0d ticks rise=%b want %0d/1", t, rise_p, L + 2);
      end
   endtask

   initial begin
      m_reset();
      @(negedge c);
      test_reset();
      test_rise_latency();
      test_rise_glitch();
      test_fall_glitch();
      test_random();
      test_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", chk, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/input_debounce_fsm.md
INPUT_DEBOUNCE_FSM -- requirements
Module: input_debounce_fsm

Interface
REQ-001 Parameter DEBOUNCE_LEN, default 4, number of consecutive identical synchronized samples required to change in_clean; legal range 1..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 4, width of the internal stability counter.
REQ-003 c  input  1  single clock; all flops on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; release is synchronous to c.
REQ-005 raw_in  input  1  asynchronous, possibly bouncing level from pad or external source.
REQ-006 in_clean  output  1  debounced level; drives the `in` port of the downstream FSM stage.
REQ-007 rise_p  output  1  one-cycle pulse when in_clean goes 0->1.
REQ-008 fall_p  output  1  one-cycle pulse when in_clean goes 1->0.
REQ-009 glitch_cnt  output  8  saturating count of rejected transitions; present only when DEBOUNCE_GLITCH_CNT_EN is defined.

Function
REQ-010 raw_in SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 feeds the FSM.
REQ-011 FSM SHALL be an enumerated type with states ST_LOW, ST_RISE, ST_HIGH, ST_FALL; state register and next-state logic separate; next-state and output decode use the voted state copy.
REQ-012 ST_LOW: sync2=0 -> stay; sync2=1 -> cnt<=1, go ST_RISE, or go ST_HIGH directly when DEBOUNCE_LEN=1.
REQ-013 ST_RISE: sync2=1 -> cnt<=cnt+1, go ST_HIGH when cnt+1==DEBOUNCE_LEN, else stay; sync2=0 -> go ST_LOW, cnt<=0, count one glitch.
REQ-014 ST_HIGH and ST_FALL SHALL mirror REQ-012/REQ-013 with polarity inverted (ST_FALL abort returns to ST_HIGH).
REQ-015 Illegal/unreachable state encoding SHALL recover to ST_LOW on the next edge, with in_clean=0 and no pulse.
REQ-016 in_clean SHALL be registered, =1 exactly when state is ST_HIGH or ST_FALL.
REQ-017 Latency: raw_in first sampled high at edge k and held stable -> in_clean=1 after edge k+1+DEBOUNCE_LEN; same for falling.
REQ-018 rise_p/fall_p SHALL be registered, asserted for exactly one cycle, coincident with the in_clean change; never both high.
REQ-019 Any sync2 toggle before DEBOUNCE_LEN stable samples SHALL abort the pending change with no effect on in_clean; the counter restarts from the next opposite sample.
REQ-020 cnt SHALL never exceed DEBOUNCE_LEN; no wrap-around.

Reset
REQ-021 rst_n=0 SHALL asynchronously force sync1=0, sync2=0, state=ST_LOW, cnt=0, in_clean=0, rise_p=0, fall_p=0, glitch_cnt=0.
REQ-022 Reset asserted mid-debounce SHALL discard the pending transition; no pulse is emitted on or after release.
REQ-023 After rst_n release with raw_in held high, in_clean SHALL rise per REQ-017, with a rise_p pulse.

Configuration
REQ-024 Macro DEBOUNCE_GLITCH_CNT_EN: defined -> glitch_cnt port and 8-bit counter present, incremented by 1 on every ST_RISE->ST_LOW or ST_FALL->ST_HIGH abort, saturating at 255; undefined -> port and counter absent, all other behaviour identical.

Verification (DEBOUNCE_LEN=4, CNT_W=4, macro defined unless stated)
REQ-025 rst_n=0 for 3 cycles, raw_in=1 throughout -> all outputs 0 during reset; after release in_clean=1 at release edge+6, rise_p one cycle.
REQ-026 raw_in 0->1 sampled at edge 10, held -> in_clean=1 and rise_p=1 after edge 15; rise_p=0 after edge 16.
REQ-027 raw_in high for 2 cycles then low -> in_clean stays 0, no pulses, glitch_cnt=1.
REQ-028 in_clean=1, raw_in low for 3 cycles then high -> in_clean stays 1, glitch_cnt increments by 1; then low held -> fall_p at sample edge+5.
REQ-029 300 alternating 2-cycle glitches -> glitch_cnt saturates at 255, in_clean unchanged; rebuild without macro -> identical in_clean/rise_p/fall_p trace.
REQ-030 rst_n pulsed low during ST_RISE with cnt=3 -> state ST_LOW, no rise_p; in_clean follows REQ-017 from release.
